morse_decoder: RTL
==================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 500, ClockIn cycles per second.
- Bit period BIT = CLOCK_FREQUENCY/2 cycles.
- Half period HALF = CLOCK_FREQUENCY/4 cycles.
REQ-002 ClockIn  input  1  the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 DotDashIn  input  1  serial Morse line; 1 = tone, 0 = silence; one code bit per BIT cycles; asynchronous to ClockIn phase.
REQ-005 LetterOut  output  3  decoded letter index, 0=A .. 7=H; holds the last successful decode.
REQ-006 LetterValid  output  1  one-cycle pulse when LetterOut has just been updated.
REQ-007 CodeError  output  1  one-cycle pulse when a captured code matches no letter.
REQ-008 RawCode  output  12  last captured 12-bit code, first-received bit in bit 11.
REQ-009 Busy  output  1  high while a code is being captured (state SHIFT or DONE).

Function
REQ-010 DotDashIn shall pass through a 2-flop synchronizer; a third flop (prev) shall provide rising-edge detect: rise = sync & ~prev.
REQ-011 The FSM shall have states IDLE, SHIFT and DONE.
REQ-012 In IDLE, on rise:
- load the sample counter with HALF-1;
- clear the bit count;
- enter SHIFT.
REQ-013 In SHIFT, the counter shall decrement every cycle; at 0 it shall produce a sample strobe and reload BIT-1.
REQ-014 Each sample strobe shall shift the synchronized line value into RawCode-capture LSB (shift left) and increment the 4-bit bit count.
REQ-015 On the strobe that captures the 12th bit, the FSM shall enter DONE the next cycle.
REQ-016 In DONE, the captured code shall be compared against the 8 letter patterns (A..H as in REQ-024).
- Match: set LetterOut to the index and pulse LetterValid.
- No match: pulse CodeError and leave LetterOut unchanged.
- In both cases: load RawCode and return to IDLE next cycle.
REQ-017 LetterValid and CodeError shall never be high in the same cycle; each shall last exactly one cycle.
REQ-018 Edges on DotDashIn during SHIFT or DONE shall be ignored; no resynchronization occurs mid-code.
REQ-019 A rise in the first IDLE cycle after DONE shall start a new capture with no dead cycle.
REQ-020 Bit count shall never exceed 12; the counter width shall be $clog2(CLOCK_FREQUENCY) bits and shall not wrap in use.
REQ-021 Latency from DotDashIn rising to the first sample strobe shall be 3 + HALF cycles (synchronizer, edge detect, HALF countdown).

Reset
REQ-022 While Reset=0, the module shall hold:
- FSM in IDLE;
- synchronizer, prev, counter and bit count at 0;
- LetterOut=0, LetterValid=0, CodeError=0, RawCode=0, Busy=0.
REQ-023 Reset asserted mid-capture shall abandon the capture with no pulse; the first rise after release shall start a fresh capture.

Structure
REQ-024 A shared package morse_pkg shall hold the 12-bit letter pattern constants:
- A=101110000000
- B=111010101000
- C=111010111010
- D=111010100000
- E=100000000000
- F=101011101000
- G=111011101000
- H=101010100000
REQ-025 morse_pkg shall also hold the FSM state enum and the constant for code length (12).
REQ-026 A sub-module morse_bit_sampler shall contain the synchronizer, the edge detect and the HALF/BIT sample counter, with outputs rise, sample strobe and synchronized bit.

Verification (CLOCK_FREQUENCY=500: BIT=250, HALF=125)
REQ-027 Drive pattern C (111010111010), one bit per 250 cycles, after reset -> LetterValid pulses once, LetterOut=2, RawCode=0xEBA, CodeError stays 0.
REQ-028 Drive E (1 then 11 zeros), with the edge offset 37 cycles from any clock phase reference -> LetterOut=4, LetterValid once, RawCode=0x800.
REQ-029 Drive 111111111111 -> CodeError pulses once, LetterOut keeps its prior value, RawCode=0xFFF.
REQ-030 Assert Reset=0 during bit 6 of pattern B, release, then drive H -> no pulse for B; LetterOut=7 after H.
REQ-031 Drive all 8 patterns back-to-back, each starting the cycle after the previous DONE -> indices 0..7 reported in order, Busy low only between codes.
REQ-032 Glitch DotDashIn high for 1 cycle during a SHIFT 0-bit, away from the sample point -> decode unaffected.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants, FSM state type and pattern lookup for the Morse decoder.
// Each letter is a fixed 12-bit on/off pattern, first-received bit in bit 11.
package morse_pkg;

  localparam int CODE_LEN = 12;

  localparam logic [CODE_LEN-1:0] PAT_A = 12'b101110000000;
  localparam logic [CODE_LEN-1:0] PAT_B = 12'b111010101000;
  localparam logic [CODE_LEN-1:0] PAT_C = 12'b111010111010;
  localparam logic [CODE_LEN-1:0] PAT_D = 12'b111010100000;
  localparam logic [CODE_LEN-1:0] PAT_E = 12'b100000000000;
  localparam logic [CODE_LEN-1:0] PAT_F = 12'b101011101000;
  localparam logic [CODE_LEN-1:0] PAT_G = 12'b111011101000;
  localparam logic [CODE_LEN-1:0] PAT_H = 12'b101010100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } match_t;

  function automatic match_t match_code(input logic [CODE_LEN-1:0] code);
    match_t m;
    m.hit = 1'b1;
    m.idx = 3'd0;
    case (code)
      PAT_A:   m.idx = 3'd0;
      PAT_B:   m.idx = 3'd1;
      PAT_C:   m.idx = 3'd2;
      PAT_D:   m.idx = 3'd3;
      PAT_E:   m.idx = 3'd4;
      PAT_F:   m.idx = 3'd5;
      PAT_G:   m.idx = 3'd6;
      PAT_H:   m.idx = 3'd7;
      default: m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/morse_bit_sampler.sv
// Synchronizes the Morse line, detects rising edges and generates mid-bit
// sample strobes: first strobe HALF cycles after start, then every BIT cycles.
module morse_bit_sampler #(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  input  logic start,
  input  logic active,
  output logic rise,
  output logic strobe,
  output logic bit_sync
);

  localparam int BIT  = CLOCK_FREQUENCY / 2;
  localparam int HALF = CLOCK_FREQUENCY / 4;
  localparam int CW   = $clog2(CLOCK_FREQUENCY);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise     = sync2 & ~prev;
  assign bit_sync = sync2;
  assign strobe   = active && (cnt == '0);

  // Counter only runs while a code is being shifted in; it idles otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(HALF - 1);
    end else if (active) begin
      if (cnt == '0) begin
        cnt <= CW'(BIT - 1);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Captures a 12-bit Morse on/off code from a serial line and decodes it to
// one of eight letters (A..H), flagging codes that match none.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic                ClockIn,
  input  logic                Reset,
  input  logic                DotDashIn,
  output logic [2:0]          LetterOut,
  output logic                LetterValid,
  output logic                CodeError,
  output logic [CODE_LEN-1:0] RawCode,
  output logic                Busy
);

  state_t              state;
  state_t              state_next;
  logic                rise;
  logic                strobe;
  logic                bit_sync;
  logic                start;
  logic                active;
  logic                last_bit;
  logic [3:0]          bit_cnt;
  logic [CODE_LEN-1:0] shift_code;
  match_t              match;

  assign start    = (state == IDLE) && rise;
  assign active   = (state == SHIFT);
  assign last_bit = strobe && (bit_cnt == 4'(CODE_LEN - 1));
  assign match    = match_code(shift_code);
  assign Busy     = (state != IDLE);

  morse_bit_sampler #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_sampler (
    .clk     (ClockIn),
    .rst_n   (Reset),
    .line    (DotDashIn),
    .start   (start),
    .active  (active),
    .rise    (rise),
    .strobe  (strobe),
    .bit_sync(bit_sync)
  );

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Edges during SHIFT/DONE are ignored because start is gated by IDLE.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      bit_cnt     <= '0;
      shift_code  <= '0;
      LetterOut   <= '0;
      LetterValid <= 1'b0;
      CodeError   <= 1'b0;
      RawCode     <= '0;
    end else begin
      LetterValid <= 1'b0;
      CodeError   <= 1'b0;
      if (start) begin
        bit_cnt    <= '0;
        shift_code <= '0;
      end else if (active && strobe) begin
        shift_code <= {shift_code[CODE_LEN-2:0], bit_sync};
        bit_cnt    <= bit_cnt + 4'd1;
      end else if (state == DONE) begin
        RawCode <= shift_code;
        if (match.hit) begin
          LetterOut   <= match.idx;
          LetterValid <= 1'b1;
        end else begin
          CodeError <= 1'b1;
        end
      end
    end
  end

endmodule
